alu_unit: RTL and testbench

- Integer execute stage directly downstream of the reservation station.
- Accepts one issued RV32I ALU/branch/jump instruction per cycle with both operands already resolved.
- Computes the result value and the next PC, then queues the outcome in a small result FIFO.
- Drives the FIFO head onto the CDB until the CDB arbiter grants it. The ROB's misprediction clear flushes the block.

---
 rtl/alu_unit.sv | 201 ++++++++++++++++++++
 tb/tb_alu_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// RV32I integer execute stage: computes result/next PC and queues outcomes for the CDB.
// Optional macro ALU_FULL_BYPASS_EN lets a full FIFO accept into the slot freed by a same-cycle pop.
module alu_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  RS2ALU_en,
  input  logic [6:0]            RS2ALU_opcode,
  input  logic [2:0]            RS2ALU_funct3,
  input  logic                  RS2ALU_funct7b5,
  input  logic [31:0]           RS2ALU_Vj,
  input  logic [31:0]           RS2ALU_Vk,
  input  logic [31:0]           RS2ALU_imm,
  input  logic [ADDR_WIDTH-1:0] RS2ALU_pc,
  input  logic [ROB_WIDTH-1:0]  RS2ALU_ROB_index,
  output logic                  ALU2RS_ready,
  input  logic                  ROB2ALU_clear,
  input  logic                  CDB2ALU_grant,
  output logic                  ALU2CDB_en,
  output logic [ROB_WIDTH-1:0]  ALU2CDB_ROB_index,
  output logic [31:0]           ALU2CDB_value,
  output logic [ADDR_WIDTH-1:0] ALU2CDB_next_pc,
  output logic                  ALU2CDB_taken
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [ROB_WIDTH-1:0]  rob;
    logic [31:0]           value;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  taken;
  } entry_t;

  entry_t                mem_q [FIFO_DEPTH];
  entry_t                mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [31:0]           op2_s;
  logic [4:0]            shamt_s;
  logic [31:0]           jalr_sum_s;
  logic [ADDR_WIDTH-1:0] pc_plus4_s;
  logic [ADDR_WIDTH-1:0] pc_imm_s;
  logic                  br_cond_s;
  logic [31:0]           res_value_s;
  logic [ADDR_WIDTH-1:0] res_next_pc_s;
  logic                  res_taken_s;
  entry_t                new_entry_s;

  logic                  full_s;
  logic                  accept_s;
  logic                  pop_s;

  // Result, next PC and taken flag for the instruction presented this cycle
  always_comb begin
    op2_s         = (RS2ALU_opcode == OPC_OP) ? RS2ALU_Vk : RS2ALU_imm;
    shamt_s       = op2_s[4:0];
    jalr_sum_s    = RS2ALU_Vj + RS2ALU_imm;
    pc_plus4_s    = RS2ALU_pc + ADDR_WIDTH'(32'd4);
    pc_imm_s      = RS2ALU_pc + ADDR_WIDTH'(RS2ALU_imm);
    br_cond_s     = 1'b0;
    res_value_s   = 32'd0;
    res_next_pc_s = pc_plus4_s;
    res_taken_s   = 1'b0;
    case (RS2ALU_opcode)
      OPC_OP, OPC_OP_IMM: begin
        case (RS2ALU_funct3)
          3'b000:  res_value_s = ((RS2ALU_opcode == OPC_OP) && RS2ALU_funct7b5) ?
                                 (RS2ALU_Vj - op2_s) : (RS2ALU_Vj + op2_s);
          3'b001:  res_value_s = RS2ALU_Vj << shamt_s;
          3'b010:  res_value_s = ($signed(RS2ALU_Vj) < $signed(op2_s)) ? 32'd1 : 32'd0;
          3'b011:  res_value_s = (RS2ALU_Vj < op2_s) ? 32'd1 : 32'd0;
          3'b100:  res_value_s = RS2ALU_Vj ^ op2_s;
          3'b101:  res_value_s = RS2ALU_funct7b5 ?
                                 $unsigned($signed(RS2ALU_Vj) >>> shamt_s) : (RS2ALU_Vj >> shamt_s);
          3'b110:  res_value_s = RS2ALU_Vj | op2_s;
          3'b111:  res_value_s = RS2ALU_Vj & op2_s;
          default: res_value_s = 32'd0;
        endcase
      end
      OPC_LUI:   res_value_s = RS2ALU_imm;
      OPC_AUIPC: res_value_s = 32'(RS2ALU_pc) + RS2ALU_imm;
      OPC_JAL: begin
        res_value_s   = 32'(pc_plus4_s);
        res_next_pc_s = pc_imm_s;
        res_taken_s   = 1'b1;
      end
      OPC_JALR: begin
        res_value_s   = 32'(pc_plus4_s);
        res_next_pc_s = ADDR_WIDTH'({jalr_sum_s[31:1], 1'b0});
        res_taken_s   = 1'b1;
      end
      OPC_BRANCH: begin
        // funct3 010/011 are undefined and fall through as not-taken with value 0
        case (RS2ALU_funct3)
          3'b000:  br_cond_s = (RS2ALU_Vj == RS2ALU_Vk);
          3'b001:  br_cond_s = (RS2ALU_Vj != RS2ALU_Vk);
          3'b100:  br_cond_s = ($signed(RS2ALU_Vj) <  $signed(RS2ALU_Vk));
          3'b101:  br_cond_s = ($signed(RS2ALU_Vj) >= $signed(RS2ALU_Vk));
          3'b110:  br_cond_s = (RS2ALU_Vj <  RS2ALU_Vk);
          3'b111:  br_cond_s = (RS2ALU_Vj >= RS2ALU_Vk);
          default: br_cond_s = 1'b0;
        endcase
        res_value_s = {31'd0, br_cond_s};
        if (br_cond_s) begin
          res_next_pc_s = pc_imm_s;
          res_taken_s   = 1'b1;
        end else begin
          res_next_pc_s = pc_plus4_s;
          res_taken_s   = 1'b0;
        end
      end
      default: begin
        res_value_s   = 32'd0;
        res_next_pc_s = pc_plus4_s;
        res_taken_s   = 1'b0;
      end
    endcase
    new_entry_s.rob     = RS2ALU_ROB_index;
    new_entry_s.value   = res_value_s;
    new_entry_s.next_pc = res_next_pc_s;
    new_entry_s.taken   = res_taken_s;
  end

  assign full_s     = (count_q == CNT_W'(FIFO_DEPTH));
  assign ALU2CDB_en = (count_q != CNT_W'(0));
`ifdef ALU_FULL_BYPASS_EN
  assign ALU2RS_ready = !full_s | (CDB2ALU_grant & ALU2CDB_en);
`else
  assign ALU2RS_ready = !full_s;
`endif
  assign accept_s = RS2ALU_en & ALU2RS_ready & rdy_in;
  assign pop_s    = ALU2CDB_en & CDB2ALU_grant & rdy_in;

  assign ALU2CDB_ROB_index = mem_q[head_q].rob;
  assign ALU2CDB_value     = mem_q[head_q].value;
  assign ALU2CDB_next_pc   = mem_q[head_q].next_pc;
  assign ALU2CDB_taken     = mem_q[head_q].taken;

  // FIFO next state: clear beats accept/pop, and a paused cycle changes nothing
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in && ROB2ALU_clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (accept_s) begin
        mem_d[tail_q] = new_entry_s;
        tail_d        = tail_q + PTR_W'(1);
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = head_q + PTR_W'(1);
      end else begin
        head_d = head_q;
      end
      case ({accept_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset that also scrubs storage
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed scenarios plus randomized traffic vs a queue model.
module tb_alu_unit;

  localparam int DEPTH = 2;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, RS2ALU_en, RS2ALU_funct7b5;
  logic [6:0]  RS2ALU_opcode;
  logic [2:0]  RS2ALU_funct3;
  logic [31:0] RS2ALU_Vj, RS2ALU_Vk, RS2ALU_imm, RS2ALU_pc;
  logic [3:0]  RS2ALU_ROB_index;
  logic        ALU2RS_ready, ROB2ALU_clear, CDB2ALU_grant, ALU2CDB_en, ALU2CDB_taken;
  logic [3:0]  ALU2CDB_ROB_index;
  logic [31:0] ALU2CDB_value, ALU2CDB_next_pc;

  alu_unit #(.ADDR_WIDTH(32), .ROB_WIDTH(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .RS2ALU_en(RS2ALU_en), .RS2ALU_opcode(RS2ALU_opcode), .RS2ALU_funct3(RS2ALU_funct3),
    .RS2ALU_funct7b5(RS2ALU_funct7b5), .RS2ALU_Vj(RS2ALU_Vj), .RS2ALU_Vk(RS2ALU_Vk),
    .RS2ALU_imm(RS2ALU_imm), .RS2ALU_pc(RS2ALU_pc), .RS2ALU_ROB_index(RS2ALU_ROB_index),
    .ALU2RS_ready(ALU2RS_ready), .ROB2ALU_clear(ROB2ALU_clear), .CDB2ALU_grant(CDB2ALU_grant),
    .ALU2CDB_en(ALU2CDB_en), .ALU2CDB_ROB_index(ALU2CDB_ROB_index), .ALU2CDB_value(ALU2CDB_value),
    .ALU2CDB_next_pc(ALU2CDB_next_pc), .ALU2CDB_taken(ALU2CDB_taken)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0]  rob;
    logic [31:0] value;
    logic [31:0] npc;
    logic        taken;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  bit   last_accept;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics of one RV32I ALU/branch/jump instruction.
  function automatic exp_t model_exec(logic [6:0] op, logic [2:0] f3, logic f7,
                                      logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                                      logic [31:0] pc, logic [3:0] tag);
    exp_t        e;
    logic [31:0] o2;
    int          sh;
    bit          cond;
    bit          legal;
    e.rob = tag; e.value = 32'd0; e.npc = pc + 32'd4; e.taken = 1'b0;
    if (op == 7'b0110011 || op == 7'b0010011) begin
      o2 = (op == 7'b0110011) ? b : imm;
      sh = int'(o2 % 32);
      case (f3)
        3'd0: e.value = (op == 7'b0110011 && f7) ? a - o2 : a + o2;
        3'd1: e.value = a << sh;
        3'd2: e.value = (int'(a) < int'(o2)) ? 32'd1 : 32'd0;
        3'd3: e.value = (a < o2) ? 32'd1 : 32'd0;
        3'd4: e.value = a ^ o2;
        3'd5: e.value = (a >> sh) | ((f7 && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
        3'd6: e.value = a | o2;
        default: e.value = a & o2;
      endcase
    end else if (op == 7'b0110111) begin
      e.value = imm;
    end else if (op == 7'b0010111) begin
      e.value = pc + imm;
    end else if (op == 7'b1101111) begin
      e.value = pc + 32'd4; e.npc = pc + imm; e.taken = 1'b1;
    end else if (op == 7'b1100111) begin
      e.value = pc + 32'd4; e.npc = (a + imm) & 32'hFFFF_FFFE; e.taken = 1'b1;
    end else if (op == 7'b1100011) begin
      legal = 1'b1;
      case (f3)
        3'd0: cond = (a == b);
        3'd1: cond = (a != b);
        3'd4: cond = (int'(a) < int'(b));
        3'd5: cond = (int'(a) >= int'(b));
        3'd6: cond = (a < b);
        3'd7: cond = (a >= b);
        default: begin cond = 1'b0; legal = 1'b0; end
      endcase
      if (legal && cond) begin
        e.npc = pc + imm; e.taken = 1'b1; e.value = 32'd1;
      end
    end
    return e;
  endfunction

  // One clock: compare DUT against the model, then advance the model across the edge.
  task automatic tick();
    bit   en_m, ready_m, accept_m, pop_m, rst_v, rdy_v, clr_v;
    exp_t e;
    #2;
    en_m    = (q.size() != 0);
    ready_m = (q.size() != DEPTH);
`ifdef ALU_FULL_BYPASS_EN
    ready_m = ready_m | (CDB2ALU_grant & en_m);
`endif
    check("en", ALU2CDB_en, en_m);
    check("ready", ALU2RS_ready, ready_m);
    if (en_m) begin
      check("tag", ALU2CDB_ROB_index, q[0].rob);
      check("value", ALU2CDB_value, q[0].value);
      check("next_pc", ALU2CDB_next_pc, q[0].npc);
      check("taken", ALU2CDB_taken, q[0].taken);
    end
    accept_m = RS2ALU_en & ready_m & rdy_in;
    pop_m    = en_m & CDB2ALU_grant & rdy_in;
    rst_v = rst_in; rdy_v = rdy_in; clr_v = ROB2ALU_clear;
    e = model_exec(RS2ALU_opcode, RS2ALU_funct3, RS2ALU_funct7b5, RS2ALU_Vj, RS2ALU_Vk,
                   RS2ALU_imm, RS2ALU_pc, RS2ALU_ROB_index);
    last_accept = accept_m && rst_v && !(rdy_v && clr_v);
    @(posedge clk_in);
    if (!rst_v || (rdy_v && clr_v)) begin
      q.delete();
    end else begin
      if (pop_m) void'(q.pop_front());
      if (accept_m) q.push_back(e);
    end
    @(negedge clk_in);
  endtask

  task automatic set_instr(logic [6:0] op, logic [2:0] f3, logic f7, logic [31:0] a,
                           logic [31:0] b, logic [31:0] imm, logic [31:0] pc, logic [3:0] tag);
    RS2ALU_opcode = op; RS2ALU_funct3 = f3; RS2ALU_funct7b5 = f7;
    RS2ALU_Vj = a; RS2ALU_Vk = b; RS2ALU_imm = imm; RS2ALU_pc = pc; RS2ALU_ROB_index = tag;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_instr();
    logic [6:0] ops [10];
    logic [31:0] imm;
    ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
            7'b1100111, 7'b1100011, 7'b0000011, 7'b1111111, 7'b0110011};
    imm = (($urandom_range(0, 1)) != 0) ? {{20{rand_word() >> 31}}, 12'($urandom)} : rand_word();
    set_instr(ops[$urandom_range(0, 9)], 3'($urandom), 1'($urandom), rand_word(),
              (($urandom_range(0, 3)) == 0) ? RS2ALU_Vj : rand_word(), imm,
              {$urandom, 2'b00} & 32'hFFFF_FFFC, 4'($urandom));
    if ($urandom_range(0, 7) == 0) RS2ALU_opcode = 7'($urandom);
  endtask

  initial begin
    exp_t        e;
    int          idx;
    logic [3:0]  seen [$];

    rst_in = 1'b0; rdy_in = 1'b1; RS2ALU_en = 1'b0; ROB2ALU_clear = 1'b0; CDB2ALU_grant = 1'b0;
    set_instr(7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    check("rst_en", ALU2CDB_en, 1'b0);
    check("rst_ready", ALU2RS_ready, 1'b1);
    check("rst_tag", ALU2CDB_ROB_index, 4'd0);
    check("rst_value", ALU2CDB_value, 32'd0);
    check("rst_npc", ALU2CDB_next_pc, 32'd0);
    check("rst_taken", ALU2CDB_taken, 1'b0);

    // Pin the model against hand-computed values.
    e = model_exec(7'b0110011, 3'd0, 1'b1, 32'd5, 32'd7, 32'd0, 32'h200, 4'd3);
    check("pin_sub", e.value, 32'hFFFF_FFFE);
    e = model_exec(7'b1100111, 3'd0, 1'b0, 32'h2003, 32'd0, 32'd4, 32'h100, 4'd1);
    check("pin_jalr", {e.value, e.npc}, {32'h104, 32'h2006});
    e = model_exec(7'b1100011, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h40, 4'd2);
    check("pin_blt", {e.value, e.npc, 31'd0, e.taken}, {32'd1, 32'h38, 32'd1});
    e = model_exec(7'b0010011, 3'd5, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 4'd0);
    check("pin_srai", e.value, 32'hF800_0000);

    // SUB with grant held
    CDB2ALU_grant = 1'b1; RS2ALU_en = 1'b1;
    set_instr(7'b0110011, 3'd0, 1'b1, 32'd5, 32'd7, 32'd0, 32'h200, 4'd3);
    tick();
    RS2ALU_en = 1'b0;
    check("sub_en", ALU2CDB_en, 1'b1);
    check("sub_tag", ALU2CDB_ROB_index, 4'd3);
    check("sub_value", ALU2CDB_value, 32'hFFFF_FFFE);
    check("sub_npc", ALU2CDB_next_pc, 32'h204);
    check("sub_taken", ALU2CDB_taken, 1'b0);
    tick();

    // JALR then BLT
    RS2ALU_en = 1'b1;
    set_instr(7'b1100111, 3'd0, 1'b0, 32'h2003, 32'd0, 32'd4, 32'h100, 4'd1);
    tick();
    check("jalr_dut", {ALU2CDB_value, ALU2CDB_next_pc, 31'd0, ALU2CDB_taken}, {32'h104, 32'h2006, 32'd1});
    set_instr(7'b1100011, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h40, 4'd2);
    tick();
    RS2ALU_en = 1'b0;
    check("blt_dut", {ALU2CDB_value, ALU2CDB_next_pc, 31'd0, ALU2CDB_taken}, {32'd1, 32'h38, 32'd1});
    tick();

    // Backpressure: three back-to-back issues with no grant
    CDB2ALU_grant = 1'b0; RS2ALU_en = 1'b1; idx = 0;
    for (int c = 0; c < 3; c++) begin
      set_instr(7'b0010011, 3'd0, 1'b0, 32'd10, 32'd0, 32'(c), 32'h300, 4'(5 + idx));
      tick();
      if (last_accept) idx++;
    end
    check("bp_accepts", 32'(idx), 32'd2);
    check("bp_ready_low", ALU2RS_ready, 1'b0);
    CDB2ALU_grant = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (ALU2CDB_en) seen.push_back(ALU2CDB_ROB_index);
      if (idx < 3) set_instr(7'b0010011, 3'd0, 1'b0, 32'd10, 32'd0, 32'd2, 32'h300, 4'(5 + idx));
      else RS2ALU_en = 1'b0;
      tick();
      if (last_accept) idx++;
    end
    check("bp_count", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) check("bp_order", {seen[0], seen[1], seen[2]}, {4'd5, 4'd6, 4'd7});

    // Flush with two entries queued, plus a simultaneous issue and grant
    CDB2ALU_grant = 1'b0; RS2ALU_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      set_instr(7'b0110111, 3'd0, 1'b0, 32'd0, 32'd0, 32'h1234_5000, 32'h400, 4'(8 + c));
      tick();
    end
    ROB2ALU_clear = 1'b1; CDB2ALU_grant = 1'b1; RS2ALU_ROB_index = 4'd11;
    tick();
    ROB2ALU_clear = 1'b0; RS2ALU_en = 1'b0; CDB2ALU_grant = 1'b0;
    check("flush_en", ALU2CDB_en, 1'b0);
    check("flush_ready", ALU2RS_ready, 1'b1);
    tick();

    // Pause: rdy_in low freezes everything
    RS2ALU_en = 1'b1;
    set_instr(7'b0010111, 3'd0, 1'b0, 32'd0, 32'd0, 32'h10, 32'h500, 4'd9);
    tick();
    rdy_in = 1'b0; CDB2ALU_grant = 1'b1; RS2ALU_ROB_index = 4'd10;
    tick();
    tick();
    check("pause_en", ALU2CDB_en, 1'b1);
    check("pause_tag", ALU2CDB_ROB_index, 4'd9);
    check("pause_value", ALU2CDB_value, 32'h510);
    rdy_in = 1'b1; RS2ALU_en = 1'b0;
    tick();
    CDB2ALU_grant = 1'b0;

`ifdef ALU_FULL_BYPASS_EN
    // Full FIFO with grant and issue: new entry takes the freed slot
    RS2ALU_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      set_instr(7'b0010011, 3'd0, 1'b0, 32'd1, 32'd0, 32'(c), 32'h600, 4'(1 + c));
      tick();
    end
    CDB2ALU_grant = 1'b1; RS2ALU_ROB_index = 4'd3;
    #2;
    check("byp_ready", ALU2RS_ready, 1'b1);
    tick();
    RS2ALU_en = 1'b0; CDB2ALU_grant = 1'b0;
    check("byp_full", ALU2RS_ready, 1'b0);
    check("byp_head", ALU2CDB_ROB_index, 4'd2);
    CDB2ALU_grant = 1'b1;
    tick();
    check("byp_next", ALU2CDB_ROB_index, 4'd3);
    tick();
    CDB2ALU_grant = 1'b0;
`endif

    // Randomized traffic, including occasional flush, pause and reset
    for (int c = 0; c < 4000; c++) begin
      rst_in        = ($urandom_range(0, 199) != 0);
      rdy_in        = ($urandom_range(0, 9) != 0);
      ROB2ALU_clear = ($urandom_range(0, 29) == 0);
      CDB2ALU_grant = ($urandom_range(0, 3) != 0);
      RS2ALU_en     = ($urandom_range(0, 3) != 0);
      rand_instr();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
